mdu_iterative: RTL and testbench

- Multi-cycle RV32M multiply/divide execution unit. It sits beside the single-cycle combinational ALU in the execute stage.
- The ALU answers in the same cycle. This block instead accepts an operation through a start/busy/done handshake and returns the result after a fixed iteration count.
- The core control stalls the PC and register writeback while busy is high. It writes out on done.

---
 rtl/mdu_iterative.sv | 182 ++++++++++++++++++
 tb/tb_mdu_iterative.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - iterative RV32M multiply/divide unit with start/busy/done handshake
// Optional zero-operand fast path enabled by defining MDU_ZERO_FAST_EN.
module mdu_iterative #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] out
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] out_q, out_d;
  logic [2:0]      op_q, op_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;

  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            special;
  logic [XLEN-1:0] special_res;

  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quot, rem, fin_res;

  // Operand signedness and magnitudes; the datapath only ever sees magnitudes.
  always_comb begin
    a_sgn = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    b_sgn = op[2] ? ~op[0] : ~op[1];
    a_neg = a_sgn & in1[XLEN-1];
    b_neg = b_sgn & in2[XLEN-1];
    a_mag = a_neg ? (~in1 + XLEN'(1)) : in1;
    b_mag = b_neg ? (~in2 + XLEN'(1)) : in2;
  end

  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (op[2] && (in2 == '0)) begin
      special     = 1'b1;
      special_res = op[1] ? in1 : '1;
    end else if (op[2] && !op[0] && (in1 == MOST_NEG) && (in2 == '1)) begin
      special     = 1'b1;
      special_res = op[1] ? '0 : in1;
`ifdef MDU_ZERO_FAST_EN
    end else if (op[2] ? (in1 == '0) : ((in1 == '0) || (in2 == '0))) begin
      special     = 1'b1;
      special_res = '0;
`endif
    end
  end

  // hi/lo form a double-width shift register: product (hi:lo) for multiply,
  // partial remainder (hi) and dividend/quotient (lo) for divide.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, b_q};
    if (op_q[2]) begin
      if (!div_diff[XLEN]) begin
        step_hi = div_diff[XLEN-1:0];
        step_lo = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        step_hi = div_sh[XLEN-1:0];
        step_lo = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign correction is applied to the final step so out is ready as FIN begins.
  always_comb begin
    prod   = {step_hi, step_lo};
    prod_s = neg_res_q ? (~prod + (2*XLEN)'(1)) : prod;
    quot   = neg_res_q ? (~step_lo + XLEN'(1)) : step_lo;
    rem    = neg_rem_q ? (~step_hi + XLEN'(1)) : step_hi;
    if (op_q[2]) begin
      fin_res = op_q[1] ? rem : quot;
    end else if (op_q[1:0] == 2'b00) begin
      fin_res = prod_s[XLEN-1:0];
    end else begin
      fin_res = prod_s[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    b_d       = b_q;
    out_d     = out_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d      = op;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (special) begin
            out_d   = special_res;
            state_d = S_FIN;
          end else begin
            hi_d    = '0;
            lo_d    = a_mag;
            b_d     = b_mag;
            cnt_d   = CW'(XLEN);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          out_d   = fin_res;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      out_q     <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      b_q       <= b_d;
      out_q     <= out_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_FIN);
  assign out  = out_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// tb/tb_mdu_iterative.sv - scoreboard bench for mdu_iterative
// Latency of zero-operand cases depends on MDU_ZERO_FAST_EN.
module tb_mdu_iterative;
  localparam int XLEN = 32;
`ifdef MDU_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif
  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [2:0]      op = 3'd0;
  logic [XLEN-1:0] in1 = '0;
  logic [XLEN-1:0] in2 = '0;
  logic            busy, done;
  logic [XLEN-1:0] out;

  always #5 clk = ~clk;

  mdu_iterative #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .in1(in1), .in2(in2), .busy(busy), .done(done), .out(out)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int passed = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          c0_q[$];
  string       name_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
  endtask

  int    busy_run = 0;
  string mname;
  int    mlat;
  always @(negedge clk) begin
    if (busy === 1'b1) busy_run = busy_run + 1;
    else busy_run = 0;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation");
      end else begin
        mname = name_q.pop_front();
        mlat  = lat_q.pop_front();
        chk({mname, "_out"}, out, exp_q.pop_front());
        chk({mname, "_lat"}, 32'(cyc - c0_q.pop_front() + 1), 32'(mlat));
        chk({mname, "_busy"}, 32'(busy_run), 32'(mlat));
      end
    end
  end

  task automatic wait_for_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      total++;
      $display("FAIL %s_timeout: got no done in 100 cycles expected done", name);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input int lat, input string name,
                       input bit push, input bit wait_it);
    @(negedge clk);
    start = 1'b1; op = o; in1 = a; in2 = b;
    @(posedge clk);
    #1;
    if (push) begin
      exp_q.push_back(expv);
      lat_q.push_back(lat);
      c0_q.push_back(cyc);
      name_q.push_back(name);
    end
    @(negedge clk);
    start = 1'b0;
    if (wait_it) wait_for_done(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_out", out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul_neg",    1, 1);
    issue(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu",      1, 1);
    issue(MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, "mulh",       1, 1);
    issue(MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, "mulhsu",     1, 1);
    issue(DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div_neg",    1, 1);
    issue(REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "rem_neg",    1, 1);
    issue(DIVU,   32'd100,      32'd7,        32'd14,       33, "divu",       1, 1);
    issue(REMU,   32'd100,      32'd7,        32'd2,        33, "remu",       1, 1);
    issue(DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1,  "div_by0",    1, 1);
    issue(REM,    32'd5,        32'd0,        32'd5,        1,  "rem_by0",    1, 1);
    issue(DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf",    1, 1);
    issue(REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  "rem_ovf",    1, 1);
    issue(MUL,    32'd0,        32'd5,        32'd0,        ZLAT, "mul_zero", 1, 1);
    issue(DIVU,   32'd0,        32'd5,        32'd0,        ZLAT, "divu_zero", 1, 1);
    issue(DIVU,   32'd7,        32'd100,      32'd0,        33, "divu_small", 1, 1);

    // start during the done cycle must be dropped
    start = 1'b1; op = MUL; in1 = 32'd1; in2 = 32'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("done_cycle_start_busy", {31'b0, busy}, 32'd0);

    issue(DIVU, 32'd100, 32'd7, 32'd14, 33, "divu_busy_start", 1, 0);
    repeat (8) @(negedge clk);
    start = 1'b1; op = MUL; in1 = 32'd3; in2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_for_done("divu_busy_start");
    issue(MUL, 32'd3, 32'd5, 32'd15, 33, "b2b_mul", 1, 1);

    issue(MUL, 32'd7, 32'd5, 32'd0, 0, "aborted", 0, 0);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", {31'b0, busy}, 32'd0);
    chk("midreset_done", {31'b0, done}, 32'd0);
    chk("midreset_out", out, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_reset_out", out, 32'd0);
    issue(MUL, 32'd3, 32'd4, 32'd12, 33, "mul_after_reset", 1, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
